// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: FSM state type, round-constant table,
// initial hash value and the bitwise helper functions used by the
// round datapath and the message schedule.
package sha256_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_FIN} fsm_e;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  // Index 0 is the leftmost entry.
  localparam logic [0:63][31:0] K_TAB = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] k_at(input logic [5:0] t);
    return K_TAB[t];
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// 16-word sliding message-schedule window.
//   clk, rst_n : clock, async active-low reset (window cleared)
//   load       : capture block_in into the window (W0 in slot 0)
//   shift      : advance one round; new word enters slot 15
//   block_in   : 512-bit block, [511:480] is W0
//   w_t        : schedule word for the current round (slot 0)
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [511:0] block_in,
  output logic [31:0]  w_t
);

  // Ascending index so a plain assignment puts the MSB word in slot 0.
  logic [0:15][31:0] w_q, w_d;
  logic [31:0]       w_new;

  assign w_new = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
  assign w_t   = w_q[0];

  always_comb begin
    w_d = w_q;
    if (load)       w_d = block_in;
    else if (shift) w_d = {w_q[1:15], w_new};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_q <= '0;
    else        w_q <= w_d;
  end

endmodule

// File: rtl/sha256_round_engine.sv
// SHA-256 compression rounds over one block, without the final chaining add.
//   clk, rst_n : clock, async active-low reset (aborts any block in flight)
//   start      : begin a block; honoured only while idle
//   block_in   : 512-bit message block, [511:480] is W0
//   hin        : starting working state, [255:224] is a, [31:0] is h
//   busy       : rounds in progress
//   done       : one-cycle pulse once state_out holds the final a..h
//   state_out  : final working variables, held until the next block finishes
module sha256_round_engine
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic [255:0] hin,
  output logic         busy,
  output logic         done,
  output logic [255:0] state_out
);

  localparam logic [6:0] LAST = 7'(ROUNDS - 1);

  fsm_e             fsm_q;
  logic [6:0]       t_q;
  logic             busy_q, done_q;
  logic [255:0]     state_out_q;
  // Slot 7 is a, slot 0 is h: same packing as hin/state_out.
  logic [7:0][31:0] st_q, st_d;
  logic [31:0]      w_t, t1, t2;
  logic             load, shift;

  assign load  = (fsm_q == ST_IDLE) && start;
  assign shift = (fsm_q == ST_ROUND);

  sha256_msg_schedule u_sched (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift    (shift),
    .block_in (block_in),
    .w_t      (w_t)
  );

  always_comb begin
    t1   = st_q[0] + big_sigma1(st_q[3]) + ch(st_q[3], st_q[2], st_q[1])
         + k_at(t_q[5:0]) + w_t;
    t2   = big_sigma0(st_q[7]) + maj(st_q[7], st_q[6], st_q[5]);
    st_d = {t1 + t2, st_q[7], st_q[6], st_q[5], st_q[4] + t1, st_q[3], st_q[2], st_q[1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= ST_IDLE;
      t_q         <= '0;
      st_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      state_out_q <= '0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            st_q   <= hin;
            t_q    <= '0;
            busy_q <= 1'b1;
            fsm_q  <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          st_q <= st_d;
          t_q  <= t_q + 7'd1;
          if (t_q == LAST) fsm_q <= ST_FIN;
        end
        ST_FIN: begin
          state_out_q <= st_q;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          fsm_q       <= ST_IDLE;
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign state_out = state_out_q;

endmodule

// File: tb/tb_sha256_round_engine.sv
module tb_sha256_round_engine;
  import sha256_pkg::*;

  logic         clk, rst_n, start;
  logic [511:0] block_in;
  logic [255:0] hin;
  logic         busy, done;
  logic [255:0] state_out;

  sha256_round_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .block_in(block_in),
    .hin(hin), .busy(busy), .done(done), .state_out(state_out)
  );

  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_DIG = {
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [511:0] M2_BLK1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] M2_BLK2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] M2_DIG = {
    32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
    32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

  typedef struct {
    int           exp_cyc;
    logic         chk_data;
    logic [255:0] hin;
    logic [255:0] digest;
  } sb_t;

  sb_t sb[$];
  int  cyc = 0;
  int  n_chk = 0, n_fail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_done at cycle %0d", cyc);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("done_cycle", 256'(cyc), 256'(e.exp_cyc));
        chk("busy_at_done", 256'(busy), 256'(0));
        if (e.chk_data) chk("digest", add8(state_out, e.hin), e.digest);
      end
    end
  end

  // Drive one start pulse; returns at the falling edge after E0 with start low.
  task automatic issue(input logic [511:0] blk, input logic [255:0] h,
                       input logic chkd, input logic [255:0] dig);
    sb_t e;
    @(negedge clk);
    start = 1'b1; block_in = blk; hin = h;
    @(posedge clk); #1;
    e.exp_cyc = cyc + 65; e.chk_data = chkd; e.hin = h; e.digest = dig;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d outstanding after %0d cycles", sb.size(), n);
      sb.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [255:0] h1;
    sb_t e;
    rst_n = 1'b0; start = 1'b0; block_in = '0; hin = '0;
    #1;
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_state_out", state_out, 256'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // "abc": round 0 then the full block.
    issue(ABC_BLK, IV, 1'b1, ABC_DIG);
    @(posedge clk); #1;
    chk("r0_a", 256'(dut.st_q[7]), 256'(32'h5d6aebcd));
    chk("r0_b", 256'(dut.st_q[6]), 256'(32'h6a09e667));
    chk("r0_e", 256'(dut.st_q[3]), 256'(32'hfa2a4622));
    drain();

    // Two-block NIST message, chained through the bench's own adder.
    issue(M2_BLK1, IV, 1'b0, '0);
    drain();
    h1 = add8(state_out, IV);
    issue(M2_BLK2, h1, 1'b1, M2_DIG);
    drain();

    // start held high: accepted at E0 and again at E0+66.
    @(negedge clk);
    start = 1'b1; block_in = ABC_BLK; hin = IV;
    @(posedge clk); #1;
    e.exp_cyc = cyc + 65;  e.chk_data = 1'b1; e.hin = IV; e.digest = ABC_DIG;
    sb.push_back(e);
    e.exp_cyc = cyc + 131;
    sb.push_back(e);
    repeat (69) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset mid-block aborts immediately.
    issue(ABC_BLK, IV, 1'b1, ABC_DIG);
    repeat (30) @(posedge clk);
    @(negedge clk);
    sb.delete();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 256'(busy), 256'(0));
    chk("abort_done", 256'(done), 256'(0));
    chk("abort_state_out", state_out, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    issue(ABC_BLK, IV, 1'b1, ABC_DIG);
    drain();

    // Inputs changed right after start must not matter.
    issue(ABC_BLK, IV, 1'b1, ABC_DIG);
    block_in = {16{32'hdeadbeef}};
    hin      = {8{32'h01234567}};
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
